fir_filter_sym_tdm: RTL and testbench
=====================================

Name: fir_filter_sym_tdm

Overview:
- Parametrised successor to the fixed 21/33-tap FIR: a symmetric-coefficient FIR with a single time-multiplexed multiplier.
- Coefficients are signed and run-time loadable. Output is rounded, scaled and saturated, and qualified by a valid strobe.
- Sits between the 3-bit sample source (600 kHz enable) and downstream 16-bit consumers on the 12 MHz domain.

Parameters:
- DATA_W, 3: signed input sample width.
- COEF_W, 16: signed coefficient width.
- TAPS, 33: filter length; must be odd, >=3.
- OUT_W, 16: signed output width.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- NUM_UNIQ (derived), (TAPS+1)/2: number of stored unique coefficients.
- ACC_W (derived), DATA_W+1+COEF_W+clog2(NUM_UNIQ): accumulator width.

Ports:
- iClk_12MHz  in  1  system clock.
- iRsn  in  1  reset; asynchronous, active-high (asserted = 1).
- iEnSample_600kHz  in  1  one-cycle sample strobe.
- iFirIn  in  DATA_W  signed input sample, sampled when the strobe = 1.
- iCoefWe  in  1  coefficient write enable.
- iCoefAddr  in  clog2(NUM_UNIQ)  coefficient index k (h[k] = h[TAPS-1-k]).
- iCoefData  in  COEF_W  signed coefficient value.
- oFirOut  out  OUT_W  signed filter output, held between updates.
- oFirValid  out  1  one-cycle pulse when oFirOut updates.
- oSat  out  1  set with oFirValid if the current output was clipped; cleared otherwise.
- oBusy  out  1  high while the MAC sequence runs.
- oOverrun  out  1  sticky; set when a strobe arrives while busy; cleared only by reset.

Behaviour:
- Reset (iRsn=1, async): delay line, coefficient RAM, accumulator, FSM=IDLE, and all outputs go to 0.
- FSM states: IDLE, MAC, ROUND, OUT.
  - IDLE: on strobe, shift iFirIn into x[0], x[i] <= x[i-1], clear accumulator, k=0, go to MAC.
  - MAC: each cycle, acc += (x[k] + x[TAPS-1-k]) * h[k] for k < NUM_UNIQ-1; at k = NUM_UNIQ-1 (centre tap), acc += x[k] * h[k]. After NUM_UNIQ cycles, go to ROUND.
  - ROUND: r = (acc + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT; saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Go to OUT.
  - OUT: register oFirOut and oSat, pulse oFirValid, return to IDLE.
- Latency: strobe at edge t gives oFirValid high in cycle t+NUM_UNIQ+2 (TAPS=33 gives 19 cycles, under the 20-cycle sample period).
- oBusy = 1 in MAC, ROUND and OUT.
- Arithmetic: all operands signed two's complement. Pre-add is DATA_W+1 bits; product is DATA_W+1+COEF_W bits, sign-extended to ACC_W; the accumulator cannot overflow.
- Strobe while busy: sample dropped, delay line untouched, oOverrun set. A strobe in the same cycle as the OUT state is also an overrun.
- Coefficient writes: accepted only when IDLE and no strobe that cycle; otherwise dropped silently. A write takes effect on the next strobe. Out-of-range iCoefAddr (>= NUM_UNIQ) is ignored.
- Reset mid-sequence: aborts immediately; no oFirValid is produced for the aborted sample.

Test Plan:
1. Impulse. TAPS=33, OUT_SHIFT=0, load h[k]=k+1 (k=0..16); strobe 1 then 0s every 20 cycles -> oFirOut sequence 1,2,...,17,16,...,1, then 0; oFirValid exactly 19 cycles after each strobe; oSat=0.
2. DC and negative input. All h=1; constant input 3 for 40 strobes -> output ramps 3,6,...,99 and holds 99. Then input -4 -> settles at -132.
3. Saturation and rounding.
   - All h=16'h7FFF, input -4 repeated, OUT_SHIFT=0 -> 33 outputs later oFirOut=16'h8000 with oSat=1.
   - OUT_SHIFT=2, h[16]=1, others 0, impulse of 3 -> output 1 (3+2>>>2), oSat=0.
4. Overrun. Second strobe 5 cycles after the first -> oOverrun=1, only one oFirValid, delay line holds only the first sample (checked by the next impulse output).
5. Write lockout. iCoefWe with addr 0, data 5 while oBusy=1 -> h[0] unchanged. The same write in IDLE -> next impulse output begins with 5.
6. Async reset mid-MAC. Assert iRsn at cycle t+8 -> all outputs 0 immediately, no valid pulse. The next impulse after release gives all-zero output (coefficients cleared).

Source files
------------

// File: rtl/fir_filter_sym_tdm.sv
// Symmetric-coefficient FIR with one time-multiplexed multiplier.
// Folds mirrored taps with a pre-adder, accumulates NUM_UNIQ products per
// sample, then rounds, scales and saturates to a strobed signed output.
module fir_filter_sym_tdm #(
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned TAPS      = 33,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                                iClk_12MHz,
  input  logic                                iRsn,
  input  logic                                iEnSample_600kHz,
  input  logic signed [DATA_W-1:0]            iFirIn,
  input  logic                                iCoefWe,
  input  logic [$clog2((TAPS+1)/2)-1:0]       iCoefAddr,
  input  logic signed [COEF_W-1:0]            iCoefData,
  output logic signed [OUT_W-1:0]             oFirOut,
  output logic                                oFirValid,
  output logic                                oSat,
  output logic                                oBusy,
  output logic                                oOverrun
);

  localparam int unsigned NUM_UNIQ = (TAPS + 1) / 2;
  localparam int unsigned ADDR_W   = $clog2(NUM_UNIQ);
  localparam int unsigned IDX_W    = $clog2(TAPS);
  localparam int unsigned PRE_W    = DATA_W + 1;
  localparam int unsigned PROD_W   = DATA_W + 1 + COEF_W;
  localparam int unsigned ACC_W    = PROD_W + ADDR_W;
  localparam int unsigned SUM_W    = ACC_W + 1;
  localparam int unsigned CMP_W    = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam int          ROUND_BIAS = int'((2 ** OUT_SHIFT) / 2);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_UNIQ - 1);
  localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [DATA_W-1:0]  r_x    [TAPS];
  logic signed [COEF_W-1:0]  r_coef [NUM_UNIQ];
  logic signed [ACC_W-1:0]   r_acc;
  logic [ADDR_W-1:0]         r_k;
  logic signed [OUT_W-1:0]   r_res;
  logic                      r_res_sat;
  logic signed [OUT_W-1:0]   r_out;
  logic                      r_valid;
  logic                      r_sat;
  logic                      r_busy;
  logic                      r_overrun;

  logic                      w_shift_en;
  logic                      w_mac_en;
  logic                      w_round_en;
  logic                      w_out_en;
  logic                      w_coef_en;
  logic                      w_overrun;
  logic [IDX_W-1:0]          w_k_idx;
  logic [IDX_W-1:0]          w_m_idx;
  logic signed [DATA_W-1:0]  w_x_lo;
  logic signed [DATA_W-1:0]  w_x_hi;
  logic signed [PRE_W-1:0]   w_pre;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [SUM_W-1:0]   w_shift;
  logic signed [CMP_W-1:0]   w_cmp;

  // State register
  always_ff @(posedge iClk_12MHz or posedge iRsn) begin
    if (iRsn) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_mac_en   = 1'b0;
    w_round_en = 1'b0;
    w_out_en   = 1'b0;
    w_coef_en  = 1'b0;
    w_overrun  = iEnSample_600kHz && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (iEnSample_600kHz) begin
          w_shift_en = 1'b1;
          w_next     = S_MAC;
        end else if (iCoefWe && (iCoefAddr <= LAST_K)) begin
          w_coef_en = 1'b1;
        end
      end
      S_MAC: begin
        w_mac_en = 1'b1;
        if (r_k == LAST_K) w_next = S_ROUND;
      end
      S_ROUND: begin
        w_round_en = 1'b1;
        w_next     = S_OUT;
      end
      S_OUT: begin
        w_out_en = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sample delay line, newest sample at index 0
  always_ff @(posedge iClk_12MHz or posedge iRsn) begin
    if (iRsn) begin
      for (int i = 0; i < int'(TAPS); i++) r_x[i] <= '0;
    end else if (w_shift_en) begin
      r_x[0] <= iFirIn;
      for (int i = 1; i < int'(TAPS); i++) r_x[i] <= r_x[i-1];
    end
  end

  // Unique coefficient store, writable only while idle
  always_ff @(posedge iClk_12MHz or posedge iRsn) begin
    if (iRsn) begin
      for (int i = 0; i < int'(NUM_UNIQ); i++) r_coef[i] <= '0;
    end else if (w_coef_en) begin
      r_coef[iCoefAddr] <= iCoefData;
    end
  end

  // Folded tap pair and product; the centre tap has no mirror partner
  assign w_k_idx = IDX_W'(r_k);
  assign w_m_idx = IDX_W'(TAPS - 1) - w_k_idx;
  assign w_x_lo  = r_x[w_k_idx];
  assign w_x_hi  = r_x[w_m_idx];
  assign w_pre   = (r_k == LAST_K) ? PRE_W'(w_x_lo) : (PRE_W'(w_x_lo) + PRE_W'(w_x_hi));
  assign w_prod  = PROD_W'(w_pre) * PROD_W'(r_coef[r_k]);

  // Accumulator and tap index
  always_ff @(posedge iClk_12MHz or posedge iRsn) begin
    if (iRsn) begin
      r_acc <= '0;
      r_k   <= '0;
    end else if (w_shift_en) begin
      r_acc <= '0;
      r_k   <= '0;
    end else if (w_mac_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
      r_k   <= r_k + ADDR_W'(1);
    end
  end

  // Round half-up, arithmetic scale, then clip to the output range
  assign w_sum   = SUM_W'(r_acc) + SUM_W'(ROUND_BIAS);
  assign w_shift = w_sum >>> OUT_SHIFT;
  assign w_cmp   = CMP_W'(w_shift);

  // Rounded result register
  always_ff @(posedge iClk_12MHz or posedge iRsn) begin
    if (iRsn) begin
      r_res     <= '0;
      r_res_sat <= 1'b0;
    end else if (w_round_en) begin
      if (w_cmp > SAT_MAX) begin
        r_res     <= SAT_MAX[OUT_W-1:0];
        r_res_sat <= 1'b1;
      end else if (w_cmp < SAT_MIN) begin
        r_res     <= SAT_MIN[OUT_W-1:0];
        r_res_sat <= 1'b1;
      end else begin
        r_res     <= OUT_W'(w_cmp);
        r_res_sat <= 1'b0;
      end
    end
  end

  // Output registers: held data, valid pulse, busy and sticky overrun
  always_ff @(posedge iClk_12MHz or posedge iRsn) begin
    if (iRsn) begin
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= w_out_en;
      r_busy  <= (w_next != S_IDLE);
      if (w_out_en) begin
        r_out <= r_res;
        r_sat <= r_res_sat;
      end
      if (w_overrun) r_overrun <= 1'b1;
    end
  end

  assign oFirOut   = r_out;
  assign oFirValid = r_valid;
  assign oSat      = r_sat;
  assign oBusy     = r_busy;
  assign oOverrun  = r_overrun;

endmodule

// File: tb/tb_fir_filter_sym_tdm.sv
// Bench for fir_filter_sym_tdm: direct-form reference model, impulse table,
// hand sequences for lockout/overrun/reset, and randomized traffic.
module tb_fir_filter_sym_tdm;

  localparam int TAPS = 33;
  localparam int NU   = 17;

  logic               clk = 1'b0;
  logic               rst;
  logic               strobe;
  logic signed [2:0]  fin;
  logic               we;
  logic [4:0]         addr;
  logic signed [15:0] cdata;

  logic signed [15:0] out0, out2;
  logic               val0, val2, sat0, sat2, busy0, busy2, ovr0, ovr2;

  int errors = 0;
  int checks = 0;

  int hist [TAPS];
  int hm   [NU];

  longint g0, g2;
  bit     gs0;

  typedef struct {
    int x;
    int exp_out;
    bit exp_sat;
  } vec_t;
  vec_t tbl [34];

  always #5 clk = ~clk;

  fir_filter_sym_tdm #(.OUT_SHIFT(0)) dut (
    .iClk_12MHz(clk), .iRsn(rst), .iEnSample_600kHz(strobe), .iFirIn(fin),
    .iCoefWe(we), .iCoefAddr(addr), .iCoefData(cdata),
    .oFirOut(out0), .oFirValid(val0), .oSat(sat0), .oBusy(busy0), .oOverrun(ovr0)
  );

  fir_filter_sym_tdm #(.OUT_SHIFT(2)) dut_s2 (
    .iClk_12MHz(clk), .iRsn(rst), .iEnSample_600kHz(strobe), .iFirIn(fin),
    .iCoefWe(we), .iCoefAddr(addr), .iCoefData(cdata),
    .oFirOut(out2), .oFirValid(val2), .oSat(sat2), .oBusy(busy2), .oOverrun(ovr2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Direct-form convolution over the full tap set, then round/scale/clip
  function automatic void model_out(input int sh, output longint r, output bit s);
    longint acc = 0;
    for (int i = 0; i < TAPS; i++)
      acc += longint'(hist[i]) * longint'(hm[(i < NU) ? i : (TAPS - 1 - i)]);
    r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
    s = 1'b0;
    if (r > 32767)       begin r = 32767;  s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
  endfunction

  function automatic void model_push(input int x);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    for (int i = 0; i < NU; i++)   hm[i] = 0;
  endfunction

  task automatic write_coef(input int a, input int d, input bit accept);
    we = 1'b1; addr = 5'(a); cdata = 16'(d);
    @(negedge clk);
    we = 1'b0;
    if (accept && a < NU) hm[a] = d;
  endtask

  // One sample period; act_k: 0 none, 1 extra strobe, 2 coef write, 3 reset
  task automatic run_sample(input int x, input int act_c, input int act_k, input int x2,
                            output longint o0, output bit os0, output longint o2);
    longint e0, e2;
    bit     es0, es2, os2;
    int     nval, lat;
    nval = 0; lat = -1;
    o0 = 0; os0 = 1'b0; o2 = 0; os2 = 1'b0;
    strobe = 1'b1; fin = 3'(x);
    model_push(x);
    model_out(0, e0, es0);
    model_out(2, e2, es2);
    @(negedge clk);
    strobe = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) chk("busy_after_strobe", busy0, 1);
      if (val0) begin
        nval++;
        if (lat < 0) begin
          lat = c;
          o0 = $signed(out0); os0 = sat0; o2 = $signed(out2); os2 = sat2;
          chk("valid_s2_aligned", val2, 1);
          chk("busy_low_at_valid", busy0, 0);
        end
      end
      strobe = 1'b0; we = 1'b0; rst = 1'b0;
      if (c == act_c) begin
        case (act_k)
          1: begin strobe = 1'b1; fin = 3'(x2); end
          2: begin we = 1'b1; addr = 5'd0; cdata = 16'sd5; end
          3: begin
            rst = 1'b1;
            #1;
            chk("rst_mid_out", out0, 0);
            chk("rst_mid_valid", val0, 0);
            chk("rst_mid_busy", busy0, 0);
            chk("rst_mid_sat", sat0, 0);
            chk("rst_mid_overrun", ovr0, 0);
            model_clear();
          end
          default: ;
        endcase
      end
      if (c < 19) @(negedge clk);
    end
    strobe = 1'b0; we = 1'b0; rst = 1'b0;
    if (act_k == 3) begin
      chk("no_valid_after_abort", nval, 0);
    end else begin
      chk("valid_count", nval, 1);
      chk("valid_latency", lat, 19);
      chk("out_shift0", o0, e0);
      chk("sat_shift0", os0, es0);
      chk("out_shift2", o2, e2);
      chk("sat_shift2", os2, es2);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) run_sample(0, -1, 0, 0, g0, gs0, g2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 34; i++) begin
      tbl[i].x       = (i == 0) ? 1 : 0;
      tbl[i].exp_out = (i <= 16) ? (i + 1) : ((i <= 32) ? (33 - i) : 0);
      tbl[i].exp_sat = 1'b0;
    end
    model_clear();

    rst = 1'b1; strobe = 1'b0; fin = '0; we = 1'b0; addr = '0; cdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", out0, 0);
    chk("reset_valid", val0, 0);
    chk("reset_sat", sat0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_overrun", ovr0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Impulse response with h[k] = k+1; out-of-range address is ignored
    for (int k = 0; k < NU; k++) write_coef(k, k + 1, 1'b1);
    write_coef(31, 100, 1'b1);
    for (int i = 0; i < 34; i++) begin
      run_sample(tbl[i].x, -1, 0, 0, g0, gs0, g2);
      chk("impulse_tbl_out", g0, tbl[i].exp_out);
      chk("impulse_tbl_sat", gs0, tbl[i].exp_sat);
    end

    // Coefficient write while busy is dropped; while idle it lands
    run_sample(1, 5, 2, 0, g0, gs0, g2);
    run_sample(1, -1, 0, 0, g0, gs0, g2);
    chk("lockout_h0_unchanged", g0, 3);
    flush(33);
    write_coef(0, 5, 1'b1);
    run_sample(1, -1, 0, 0, g0, gs0, g2);
    chk("idle_write_h0", g0, 5);

    // Strobe while in MAC is an overrun and leaves the delay line alone
    chk("overrun_clear_before", ovr0, 0);
    run_sample(1, 4, 1, -1, g0, gs0, g2);
    chk("overrun_set_mac", ovr0, 1);
    run_sample(0, -1, 0, 0, g0, gs0, g2);
    run_sample(0, -1, 0, 0, g0, gs0, g2);

    // DC ramp and negative settle with unity coefficients
    for (int k = 0; k < NU; k++) write_coef(k, 1, 1'b1);
    for (int i = 0; i < 40; i++) run_sample(3, -1, 0, 0, g0, gs0, g2);
    chk("dc_pos_final", g0, 99);
    for (int i = 0; i < 40; i++) run_sample(-4, -1, 0, 0, g0, gs0, g2);
    chk("dc_neg_final", g0, -132);

    // Negative saturation with full-scale coefficients
    for (int k = 0; k < NU; k++) write_coef(k, 32767, 1'b1);
    for (int i = 0; i < 33; i++) run_sample(-4, -1, 0, 0, g0, gs0, g2);
    chk("sat_clip_out", g0, -32768);
    chk("sat_clip_flag", gs0, 1);

    // Rounding on the scaled instance: centre tap only, impulse of 3
    for (int k = 0; k < NU; k++) write_coef(k, (k == 16) ? 1 : 0, 1'b1);
    flush(33);
    for (int i = 0; i < 17; i++) begin
      run_sample((i == 0) ? 3 : 0, -1, 0, 0, g0, gs0, g2);
      if (i == 16) begin
        chk("round_s2_out", g2, 1);
        chk("round_s0_out", g0, 3);
      end
    end
    run_sample(-3, -1, 0, 0, g0, gs0, g2);
    flush(17);

    // Async reset mid-MAC aborts and clears the coefficient store
    for (int k = 0; k < NU; k++) write_coef(k, k + 1, 1'b1);
    run_sample(1, -1, 0, 0, g0, gs0, g2);
    run_sample(0, 8, 3, 0, g0, gs0, g2);
    run_sample(1, -1, 0, 0, g0, gs0, g2);
    chk("post_reset_zero", g0, 0);

    // Strobe landing in the OUT cycle is also an overrun
    for (int k = 0; k < NU; k++) write_coef(k, k + 1, 1'b1);
    chk("overrun_clear_after_rst", ovr0, 0);
    run_sample(2, 18, 1, 1, g0, gs0, g2);
    chk("overrun_set_out", ovr0, 1);
    run_sample(0, -1, 0, 0, g0, gs0, g2);

    // Randomized coefficients and samples against the model
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) begin
        for (int k = 0; k < NU; k++) begin
          if ($urandom_range(0, 1) == 1)
            write_coef(k, int'($signed(16'($urandom))), 1'b1);
          else
            write_coef(k, int'($urandom_range(0, 400)) - 200, 1'b1);
        end
      end
      run_sample(int'($urandom_range(0, 7)) - 4, -1, 0, 0, g0, gs0, g2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
